cp_insert: RTL and testbench

OFDM TX cyclic-prefix inserter for the 802.16 chain: sits after the IFFT and ahead of the TX front end, and is the transmit-side counterpart of RX CP removal ahead of the FFT. It collects NFFT time-domain samples per symbol into a ping-pong buffer. It then streams CP_LEN + NFFT samples out: the last CP_LEN samples first, then the whole symbol. Both sides use the same Wishbone-style streaming handshake as the rest of the datapath.

---
 rtl/cp_insert.sv | 205 ++++++++++++++++++++
 tb/tb_cp_insert.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_insert.sv
// cp_insert: OFDM TX cyclic-prefix inserter.
// Collects NFFT samples per symbol into a ping-pong buffer. Each symbol is
// then streamed out as its last CP_LEN samples followed by the whole symbol.
// Both sides use a Wishbone-style streaming handshake.
// Optional feature: define CP_INSERT_SYMCNT_EN to add the SYM_CNT_O symbol counter.
module cp_insert #(
  parameter int NFFT   = 256,
  parameter int CP_LEN = 64,
  parameter int DW     = 32
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] DAT_I,
  input  logic          WE_I,
  input  logic          STB_I,
  input  logic          CYC_I,
  output logic          ACK_O,
  output logic [DW-1:0] DAT_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I
`ifdef CP_INSERT_SYMCNT_EN
  ,
  output logic [15:0]   SYM_CNT_O
`endif
);

  localparam int AW = $clog2(NFFT);
  localparam int RW = AW + 1;
  localparam logic [AW-1:0] WI_LAST    = AW'(NFFT - 1);
  localparam logic [AW-1:0] CP_BASE    = AW'(NFFT - CP_LEN);
  localparam logic [AW-1:0] CP_OFF     = AW'(CP_LEN);
  localparam logic [RW-1:0] RC_CP_LAST = RW'(CP_LEN - 1);
  localparam logic [RW-1:0] RC_LAST    = RW'(NFFT + CP_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} state_t;

  // Two banks of NFFT samples, addressed as {bank, index}
  logic [DW-1:0] mem_q [2*NFFT];

  logic [1:0]    full_q, full_d;
  logic          wb_q, wb_d;
  logic [AW-1:0] wi_q, wi_d;
  logic          in_xfer, wr_last;

  state_t        state_q, state_d;
  logic          rb_q, rb_d;
  logic [RW-1:0] rc_q, rc_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          stb_q, stb_d;
  logic          cyc_q, cyc_d;
  logic          last_q, last_d;
  logic          ld, rd_done, sym_end;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  // Input side accepts only into a bank that is not waiting to be drained
  assign ACK_O   = RST_I & ~full_q[wb_q];
  assign in_xfer = CYC_I & STB_I & WE_I & ACK_O;
  assign wr_last = in_xfer & (wi_q == WI_LAST);

  // Output register advances whenever it is empty or being consumed
  assign ld      = ~stb_q | ACK_I;
  // The final BODY sample sitting in the output register is taken this cycle
  assign sym_end = stb_q & ACK_I & last_q;

  assign DAT_O = dat_q;
  assign STB_O = stb_q;
  assign WE_O  = stb_q;
  assign CYC_O = cyc_q;

  // Write pointer/index: advance on transfer, drop a partial symbol when CYC_I falls
  always_comb begin
    wb_d = wb_q;
    wi_d = wi_q;
    if (in_xfer) begin
      if (wr_last) begin
        wb_d = ~wb_q;
        wi_d = '0;
      end else begin
        wi_d = wi_q + 1'b1;
      end
    end else if (!CYC_I) begin
      wi_d = '0;
    end
  end

  // Sample storage; data path only, no reset needed
  always_ff @(posedge CLK_I) begin
    if (in_xfer) mem_q[{wb_q, wi_q}] <= DAT_I;
  end

  // Read address: prefix walks the symbol tail, body walks from sample 0
  always_comb begin
    if (state_q == S_CP) rd_addr = CP_BASE + rc_q[AW-1:0];
    else                 rd_addr = rc_q[AW-1:0] - CP_OFF;
  end

  assign rd_data = mem_q[{rb_q, rd_addr}];

  // Read FSM and output register next-state
  always_comb begin
    state_d = state_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    dat_d   = dat_q;
    stb_d   = stb_q;
    cyc_d   = cyc_q;
    last_d  = last_q;
    rd_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld) begin
          stb_d  = 1'b0;
          last_d = 1'b0;
        end
        if (full_q[rb_q]) begin
          state_d = S_CP;
          rc_d    = '0;
        end
      end
      S_CP: begin
        if (ld) begin
          dat_d  = rd_data;
          stb_d  = 1'b1;
          last_d = 1'b0;
          rc_d   = rc_q + 1'b1;
          if (rc_q == '0) cyc_d = 1'b1;
          if (rc_q == RC_CP_LAST) state_d = S_BODY;
        end
      end
      S_BODY: begin
        if (ld) begin
          dat_d  = rd_data;
          stb_d  = 1'b1;
          last_d = (rc_q == RC_LAST);
          rc_d   = rc_q + 1'b1;
          if (rc_q == RC_LAST) begin
            rd_done = 1'b1;
            rc_d    = '0;
            rb_d    = ~rb_q;
            state_d = full_q[~rb_q] ? S_CP : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Drop the cycle only when no next symbol is following straight on
    if (sym_end && (state_q == S_IDLE)) cyc_d = 1'b0;
  end

  // Full flags: writer sets its bank, reader clears its bank, both may happen at once
  always_comb begin
    full_d = full_q;
    if (wr_last) full_d[wb_q] = 1'b1;
    if (rd_done) full_d[rb_q] = 1'b0;
  end

  // Control and output registers
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      full_q  <= '0;
      wb_q    <= 1'b0;
      wi_q    <= '0;
      state_q <= S_IDLE;
      rb_q    <= 1'b0;
      rc_q    <= '0;
      dat_q   <= '0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      full_q  <= full_d;
      wb_q    <= wb_d;
      wi_q    <= wi_d;
      state_q <= state_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      dat_q   <= dat_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
      last_q  <= last_d;
    end
  end

`ifdef CP_INSERT_SYMCNT_EN
  logic [15:0] sym_cnt_q, sym_cnt_d;

  // Count completed symbols, wrapping naturally at 16 bits
  always_comb begin
    sym_cnt_d = sym_cnt_q;
    if (sym_end) sym_cnt_d = sym_cnt_q + 16'd1;
  end

  // Symbol counter register
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) sym_cnt_q <= '0;
    else        sym_cnt_q <= sym_cnt_d;
  end

  assign SYM_CNT_O = sym_cnt_q;
`endif

endmodule

// File: tb/tb_cp_insert.sv
// tb_cp_insert: directed bench for cp_insert (default NFFT=256/CP_LEN=64 instance
// plus a CP_LEN=8 instance sharing the same inputs).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cp_insert;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [31:0] DAT_I;
  logic        WE_I, STB_I, CYC_I, ACK_I;
  logic        ACK_O, CYC_O, STB_O, WE_O;
  logic [31:0] DAT_O;
  logic        ACK_O8, CYC_O8, STB_O8, WE_O8;
  logic [31:0] DAT_O8;
`ifdef CP_INSERT_SYMCNT_EN
  logic [15:0] SYM_CNT_O, SYM_CNT_O8;
`endif

  always #5 CLK_I = ~CLK_I;

  cp_insert #(.NFFT(256), .CP_LEN(64), .DW(32)) u_dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I),
    .CYC_I(CYC_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
    .WE_O(WE_O), .ACK_I(ACK_I)
`ifdef CP_INSERT_SYMCNT_EN
    , .SYM_CNT_O(SYM_CNT_O)
`endif
  );

  cp_insert #(.NFFT(256), .CP_LEN(8), .DW(32)) u_dut8 (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I),
    .CYC_I(CYC_I), .ACK_O(ACK_O8), .DAT_O(DAT_O8), .CYC_O(CYC_O8), .STB_O(STB_O8),
    .WE_O(WE_O8), .ACK_I(ACK_I)
`ifdef CP_INSERT_SYMCNT_EN
    , .SYM_CNT_O(SYM_CNT_O8)
`endif
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] obs_q[$];
  logic [31:0] obs8_q[$];
  int          cyc_rises = 0, cyc_hi = 0, ack_low = 0, stall_cnt = 0, stab_err = 0;
  logic        hold_prev = 1'b0, cyc_prev = 1'b0;
  logic [31:0] dat_prev = '0;
  bit          rand_en = 1'b0;

  // Output monitor: records accepted beats and handshake statistics
  always @(negedge CLK_I) begin
    if (STB_O && ACK_I) obs_q.push_back(DAT_O);
    if (STB_O8 && ACK_I) obs8_q.push_back(DAT_O8);
    if (CYC_O && !cyc_prev) cyc_rises <= cyc_rises + 1;
    if (CYC_O) cyc_hi <= cyc_hi + 1;
    if (CYC_I && STB_I && WE_I && !ACK_O) ack_low <= ack_low + 1;
    if (hold_prev) begin
      stall_cnt <= stall_cnt + 1;
      if (!STB_O || (DAT_O !== dat_prev)) stab_err <= stab_err + 1;
    end
    hold_prev <= STB_O && !ACK_I;
    dat_prev  <= DAT_O;
    cyc_prev  <= CYC_O;
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
    if (rand_en) ACK_I = 1'($urandom_range(0, 1));
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample and hold it until accepted
  task automatic put(input logic [31:0] d);
    int g = 0;
    DAT_I = d;
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    while (!ACK_O && g < 2000) begin
      tick();
      g++;
    end
    if (g >= 2000) chk("put_timeout", 64'(ACK_O), 64'd1);
    tick();
    STB_I = 1'b0;
    WE_I  = 1'b0;
  endtask

  task automatic do_reset();
    RST_I = 1'b0;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    repeat (3) tick();
    RST_I = 1'b1;
    tick();
    obs_q.delete();
    obs8_q.delete();
  endtask

  task automatic wait_beats(input int which, input int n);
    int g = 0;
    while (((which == 0) ? obs_q.size() : obs8_q.size()) < n && g < 5000) begin
      tick();
      g++;
    end
  endtask

  // Expected stream: per symbol, tail CP samples then whole symbol, value base+s*256+idx
  task automatic check_seq(input string tag, input int which, input int nsym,
                           input int cp, input int base);
    int bad = 0;
    int k, idx, sz;
    logic [31:0] e, o;
    sz = (which == 0) ? obs_q.size() : obs8_q.size();
    for (int s = 0; s < nsym; s++) begin
      for (int j = 0; j < cp + 256; j++) begin
        k   = s * (cp + 256) + j;
        idx = (j < cp) ? (256 - cp + j) : (j - cp);
        e   = 32'(base + s * 256 + idx);
        if (k < sz) begin
          o = (which == 0) ? obs_q[k] : obs8_q[k];
          if (o !== e) bad++;
        end
      end
    end
    chk({tag, "_mism"}, 64'(bad), 64'd0);
  endtask

  int c_r0, c_h0, a0, s0, e0;

  initial begin
    RST_I = 1'b0;
    DAT_I = '0;
    WE_I  = 1'b0;
    STB_I = 1'b0;
    CYC_I = 1'b0;
    ACK_I = 1'b1;
    repeat (3) tick();
    chk("rst_dat", 64'(DAT_O), 64'd0);
    chk("rst_stb", 64'(STB_O), 64'd0);
    chk("rst_cyc", 64'(CYC_O), 64'd0);
    chk("rst_we", 64'(WE_O), 64'd0);
    chk("rst_ack", 64'(ACK_O), 64'd0);
    chk("rst_ack8", 64'(ACK_O8), 64'd0);
`ifdef CP_INSERT_SYMCNT_EN
    chk("rst_symcnt", 64'(SYM_CNT_O), 64'd0);
`endif
    RST_I = 1'b1;
    tick();
    chk("ack_after_rst", 64'(ACK_O), 64'd1);
    obs_q.delete();
    obs8_q.delete();

    // Single symbol, ACK_I held high
    for (int i = 0; i < 256; i++) put(32'(i));
    CYC_I = 1'b0;
    chk("t1_stb_k", 64'(STB_O), 64'd0);
    tick();
    chk("t1_stb_k1", 64'(STB_O), 64'd0);
    tick();
    chk("t1_stb_k2", 64'(STB_O), 64'd1);
    chk("t1_dat_k2", 64'(DAT_O), 64'd192);
    chk("t1_we_k2", 64'(WE_O), 64'd1);
    chk("t1_cyc_k2", 64'(CYC_O), 64'd1);
    wait_beats(0, 320);
    chk("t1_cyc_end", 64'(CYC_O), 64'd0);
    chk("t1_stb_end", 64'(STB_O), 64'd0);
    repeat (20) tick();
    chk("t1_beats", 64'(obs_q.size()), 64'd320);
    check_seq("t1", 0, 1, 64, 0);

    // Three back-to-back symbols with continuous input
    do_reset();
    c_r0 = cyc_rises;
    c_h0 = cyc_hi;
    a0   = ack_low;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 256; i++) put(32'(s * 256 + i));
    CYC_I = 1'b0;
    wait_beats(0, 960);
    repeat (5) tick();
    chk("t2_beats", 64'(obs_q.size()), 64'd960);
    check_seq("t2", 0, 3, 64, 0);
    chk("t2_cyc_rises", 64'(cyc_rises - c_r0), 64'd1);
    chk("t2_cyc_hi", 64'(cyc_hi - c_h0), 64'd960);
    chk("t2_acko_low", 64'(ack_low > a0), 64'd1);
`ifdef CP_INSERT_SYMCNT_EN
    chk("t2_symcnt", 64'(SYM_CNT_O), 64'd3);
`endif

    // Random downstream back-pressure
    do_reset();
    s0 = stall_cnt;
    e0 = stab_err;
    rand_en = 1'b1;
    for (int i = 0; i < 256; i++) put(32'(32'h1000 + i));
    CYC_I = 1'b0;
    wait_beats(0, 320);
    rand_en = 1'b0;
    ACK_I   = 1'b1;
    repeat (10) tick();
    chk("t3_beats", 64'(obs_q.size()), 64'd320);
    check_seq("t3", 0, 1, 64, 32'h1000);
    chk("t3_stalled", 64'(stall_cnt > s0), 64'd1);
    chk("t3_stable", 64'(stab_err - e0), 64'd0);

    // Partial symbol discarded when CYC_I drops
    do_reset();
    for (int i = 0; i < 100; i++) put(32'(32'h2000 + i));
    CYC_I = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 256; i++) put(32'(i));
    CYC_I = 1'b0;
    wait_beats(0, 320);
    repeat (30) tick();
    chk("t4_beats", 64'(obs_q.size()), 64'd320);
    chk("t4_first", 64'((obs_q.size() > 0) ? obs_q[0] : 32'hFFFF_FFFF), 64'd192);
    check_seq("t4", 0, 1, 64, 0);

    // Reset in the middle of output, then one fresh symbol
    do_reset();
    for (int i = 0; i < 256; i++) put(32'(32'h3000 + i));
    CYC_I = 1'b0;
    wait_beats(0, 150);
    RST_I = 1'b0;
    #1;
    chk("t5_rst_dat", 64'(DAT_O), 64'd0);
    chk("t5_rst_stb", 64'(STB_O), 64'd0);
    chk("t5_rst_cyc", 64'(CYC_O), 64'd0);
    chk("t5_rst_we", 64'(WE_O), 64'd0);
    chk("t5_rst_ack", 64'(ACK_O), 64'd0);
    repeat (3) tick();
    RST_I = 1'b1;
    tick();
    obs_q.delete();
    for (int i = 0; i < 256; i++) put(32'(32'h4000 + i));
    CYC_I = 1'b0;
    wait_beats(0, 320);
    repeat (400) tick();
    chk("t5_beats", 64'(obs_q.size()), 64'd320);
    check_seq("t5", 0, 1, 64, 32'h4000);

    // CP_LEN = 8 instance, one symbol
    do_reset();
    for (int i = 0; i < 256; i++) put(32'(i));
    CYC_I = 1'b0;
    tick();
    tick();
    chk("t6_dat8_first", 64'(DAT_O8), 64'd248);
    chk("t6_we8", 64'(WE_O8), 64'd1);
    wait_beats(1, 264);
    chk("t6_cyc8_end", 64'(CYC_O8), 64'd0);
    repeat (10) tick();
    chk("t6_beats8", 64'(obs8_q.size()), 64'd264);
    check_seq("t6", 1, 1, 8, 0);
`ifdef CP_INSERT_SYMCNT_EN
    chk("t6_symcnt8", 64'(SYM_CNT_O8), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
